mux8x1_rr_arb: RTL and testbench
================================

# mux8x1_rr_arb

Round-robin arbiter and sequencer for the 8:1 bit mux, sharing it among eight requesters. Each requester raises `req[k]` to have input `i[k]` routed to the output. The block drives the mux select `s` and a one-hot grant `gnt`, limits each tenure to `HOLD_MAX` cycles, and presents a registered `y`/`valid` pair. It sits between the eight requesting sources and the downstream single-bit consumer, replacing a free-running or externally driven select.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles a single grant is held. Legal range 1..255.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 8: request vector; `req[k]` asks for source k.
- `i` input 8: mux data inputs; `i[k]` belongs to requester k.
- `gnt` output 8: one-hot grant, registered; all-zero when idle.
- `s` output 3: mux select, registered; index of the current or most recent grant.
- `y` output 1: registered mux output, equal to `i[s]` sampled on the previous edge while granted.
- `valid` output 1: registered; high when `y` carries granted data.

## Operation
- State: `state` (IDLE/GRANT), `ptr[2:0]` (search start), `cnt` (width clog2(HOLD_MAX+1)), plus the output registers.
- Reset, checked at every edge regardless of state: `state`=IDLE, `gnt`=0, `s`=0, `ptr`=0, `cnt`=0, `y`=0, `valid`=0. A reset asserted mid-grant clears everything on that edge with no completion.
- **Arbitrate(start):** the winner is the first set `req` bit searching indices start, start+1, … start+7 (mod 8).
- **IDLE:**
  - If `req`==0, stay in IDLE and keep `gnt`=0. `s` holds its last value.
  - Otherwise, winner w = Arbitrate(`ptr`). Set `gnt`=1<<w, `s`=w, `cnt`=1, and go to GRANT.
- **GRANT, with current holder h=`s`:**
  - Release occurs when `req[h]`==0 or `cnt`==HOLD_MAX.
  - If there is no release, `cnt`++ and `gnt`/`s` are held.
  - On release, `ptr`=h+1 mod 8 and winner w = Arbitrate(h+1).
    - The search reaches h last, so h re-wins only as the sole requester.
    - If a winner exists, set `gnt`=1<<w, `s`=w, `cnt`=1, and stay in GRANT. There is no idle bubble.
    - If no winner exists, set `gnt`=0, `cnt`=0, and go to IDLE.
- **Data path:**
  - Every edge: `valid` <= (state==GRANT), and `y` <= (state==GRANT) ? `i[s]` : 0.
  - Both use the pre-edge `state` and `s`.
- `gnt` is never multi-hot. `gnt` is nonzero exactly when state==GRANT.

## Timing
- **Grant latency:** a request sampled high at edge n while idle gives `gnt`/`s` valid after edge n.
- **Data latency:** `y`/`valid` follow one cycle after `gnt`, i.e. after edge n+1.
- **Tenure:** `gnt` is held for min(HOLD_MAX, number of edges at which `req[h]` is still sampled high, +1 counting the grant edge) cycles.
- **Requester drop:** a requester that drops `req` exactly when satisfied sees no extra grant cycle. Dropping is detected at the first edge where it samples low.
- **Handover:** the grant moves between requesters on a single edge. `valid` stays high continuously across back-to-back grants.
- **Wrap:** after a grant to 7, `ptr`=0 and the search order is 0,1,…,7.
- **Simultaneous events:** a new requester arriving on the same edge as a release is included in that arbitration. A request appearing and vanishing between edges is invisible.
- **Held data:** `y` is the sampled value of `i[s]`. `i` changes are seen one cycle later.

## Test plan
- **Reset mid-grant:** with `req`=0x08 granted for 2 cycles, assert `rst` for 1 cycle -> after that edge `gnt`=0, `s`=0, `y`=0, `valid`=0. Deassert `rst` -> `gnt`=0x08 one edge later.
- **Sole requester re-grant:** HOLD_MAX=4, `req`=0x04 held for 10 cycles -> `gnt`=0x04 continuously for 10 cycles. `cnt` runs 1,2,3,4,1,2,… and `s`=2 throughout.
- **Full rotation and wrap:** HOLD_MAX=4, `req`=0xFF constant from reset -> `gnt` sequence 0x01,0x02,…,0x80,0x01, each held 4 cycles with no gaps. `valid` stays high from the second cycle onward.
- **Early drop:** `req`=0x08 for 2 cycles, then `req`=0x00 -> `gnt`=0x08 for exactly 2 cycles, then 0. `valid` is high for 2 cycles, lagging by 1.
- **Fairness after wrap:** `req`=0x81 held. After the grant to 7 releases (HOLD_MAX=2), the next grant is 0x01, then 0x80, alternating every 2 cycles.
- **Data integrity:** `req`=0xFF, `i`=0xA5 static, HOLD_MAX=1 -> `y` tracks 1,0,1,0,0,1,0,1 for `s`=0..7, each one cycle after the corresponding `s`.

Source files
------------

// File: rtl/mux8x1_rr_arb_if.sv
// Request/data bundle between the eight sources, the arbiter and the downstream consumer.
// master: arbiter side (drives grant, select and registered data); slave: requester/consumer side.
interface mux8x1_rr_arb_if;
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       y;
    logic       valid;

    modport master (
        input  req,
        input  i,
        output gnt,
        output s,
        output y,
        output valid
    );

    modport slave (
        output req,
        output i,
        input  gnt,
        input  s,
        input  y,
        input  valid
    );
endinterface

// File: rtl/mux8x1_rr_arb.sv
// Round-robin arbiter sharing an 8:1 bit mux; grant/select valid one edge after request, y/valid one edge later.
// Tenure capped at HOLD_MAX cycles; handover between requesters happens on a single edge with no idle bubble.
module mux8x1_rr_arb #(
    parameter int HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux8x1_rr_arb_if.master     bus
);
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     gnt_q, gnt_d;
    logic [2:0]     s_q, s_d;
    logic           y_q, y_d;
    logic           valid_q, valid_d;

    logic [3:0]     arb_idle;
    logic [3:0]     arb_next;
    logic           release_c;
    logic [2:0]     s_plus1;

    // Returns {found, index}; walks offsets downward so the smallest offset from start wins.
    function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign s_plus1   = s_q + 3'd1;
    assign arb_idle  = arbitrate(bus.req, ptr_q);
    assign arb_next  = arbitrate(bus.req, s_plus1);
    assign release_c = !bus.req[s_q] || (cnt_q == HOLD_C);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        valid_d = (state_q == GRANT);
        y_d     = (state_q == GRANT) ? bus.i[s_q] : 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (arb_idle[3]) begin
                    gnt_d   = 8'(1) << arb_idle[2:0];
                    s_d     = arb_idle[2:0];
                    cnt_d   = CW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!release_c) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // Searching from h+1 puts the current holder last in line.
                    ptr_d = s_plus1;
                    if (arb_next[3]) begin
                        gnt_d = 8'(1) << arb_next[2:0];
                        s_d   = arb_next[2:0];
                        cnt_d = CW'(1);
                    end else begin
                        gnt_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            s_q     <= '0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.s     = s_q;
    assign bus.y     = y_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_mux8x1_rr_arb.sv
// Bench for mux8x1_rr_arb: three instances (HOLD_MAX 4, 2, 1) share one stimulus stream and a queue-free reference model.
module tb_mux8x1_rr_arb;
    logic       clk = 1'b0;
    logic       rst_r = 1'b1;
    logic [7:0] req_r = '0;
    logic [7:0] i_r = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mux8x1_rr_arb_if if4 ();
    mux8x1_rr_arb_if if2 ();
    mux8x1_rr_arb_if if1 ();

    assign if4.req = req_r;  assign if4.i = i_r;
    assign if2.req = req_r;  assign if2.i = i_r;
    assign if1.req = req_r;  assign if1.i = i_r;

    mux8x1_rr_arb #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst_r), .bus(if4));
    mux8x1_rr_arb #(.HOLD_MAX(2)) dut2 (.clk(clk), .rst(rst_r), .bus(if2));
    mux8x1_rr_arb #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst_r), .bus(if1));

    logic [7:0] g_a [3];
    logic [2:0] s_a [3];
    logic       y_a [3];
    logic       v_a [3];
    assign g_a[0] = if4.gnt; assign s_a[0] = if4.s; assign y_a[0] = if4.y; assign v_a[0] = if4.valid;
    assign g_a[1] = if2.gnt; assign s_a[1] = if2.s; assign y_a[1] = if2.y; assign v_a[1] = if2.valid;
    assign g_a[2] = if1.gnt; assign s_a[2] = if1.s; assign y_a[2] = if1.y; assign v_a[2] = if1.valid;

    // Reference model: owner is -1 when idle, tenure counts cycles held by the owner.
    int holds [3] = '{4, 2, 1};
    int m_owner [3] = '{-1, -1, -1};
    int m_ten [3] = '{0, 0, 0};
    int m_start [3] = '{0, 0, 0};
    int m_last [3] = '{0, 0, 0};
    bit m_y [3] = '{0, 0, 0};
    bit m_valid [3] = '{0, 0, 0};

    function automatic int pick(logic [7:0] rq, int start);
        for (int k = 0; k < 8; k++) begin
            if (rq[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(bit r, logic [7:0] rq, logic [7:0] iv);
        int w;
        for (int n = 0; n < 3; n++) begin
            if (r) begin
                m_owner[n] = -1; m_ten[n] = 0; m_start[n] = 0;
                m_last[n] = 0;   m_y[n] = 0;   m_valid[n] = 0;
            end else begin
                m_valid[n] = (m_owner[n] >= 0);
                m_y[n]     = (m_owner[n] >= 0) ? iv[m_last[n]] : 1'b0;
                if (m_owner[n] < 0) begin
                    w = pick(rq, m_start[n]);
                    if (w >= 0) begin
                        m_owner[n] = w; m_ten[n] = 1; m_last[n] = w;
                    end
                end else if (rq[m_owner[n]] && m_ten[n] < holds[n]) begin
                    m_ten[n]++;
                end else begin
                    m_start[n] = (m_owner[n] + 1) % 8;
                    w = pick(rq, m_start[n]);
                    if (w >= 0) begin
                        m_owner[n] = w; m_ten[n] = 1; m_last[n] = w;
                    end else begin
                        m_owner[n] = -1; m_ten[n] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        bit         r;
        logic [7:0] rq;
        logic [7:0] iv;
        r = rst_r; rq = req_r; iv = i_r;
        @(posedge clk);
        model_step(r, rq, iv);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        logic [7:0] eg;
        for (int n = 0; n < 3; n++) begin
            eg = (m_owner[n] >= 0) ? (8'(1) << m_owner[n]) : 8'h00;
            chk($sformatf("%s h%0d gnt", tag, holds[n]), 32'(g_a[n]), 32'(eg));
            chk($sformatf("%s h%0d s", tag, holds[n]), 32'(s_a[n]), 32'(m_last[n]));
            chk($sformatf("%s h%0d y", tag, holds[n]), 32'(y_a[n]), 32'(m_y[n]));
            chk($sformatf("%s h%0d valid", tag, holds[n]), 32'(v_a[n]), 32'(m_valid[n]));
        end
    endtask

    task automatic do_reset();
        rst_r = 1'b1; req_r = '0;
        tick();
        rst_r = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic [7:0] i;
        logic [7:0] gnt;
        logic [2:0] s;
        bit         y;
        bit         valid;
    } vec_t;

    vec_t vt [13];
    bit   y_seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        // Expected values apply to the HOLD_MAX=4 instance after the edge that samples the inputs.
        vt[0]  = '{1, 8'h00, 8'hFF, 8'h00, 3'd0, 0, 0};
        vt[1]  = '{0, 8'h08, 8'hFF, 8'h08, 3'd3, 0, 0};
        vt[2]  = '{0, 8'h08, 8'hFF, 8'h08, 3'd3, 1, 1};
        vt[3]  = '{0, 8'h00, 8'hFF, 8'h00, 3'd3, 1, 1};
        vt[4]  = '{0, 8'h00, 8'hFF, 8'h00, 3'd3, 0, 0};
        vt[5]  = '{0, 8'h08, 8'h00, 8'h08, 3'd3, 0, 0};
        vt[6]  = '{0, 8'h08, 8'h00, 8'h08, 3'd3, 0, 1};
        vt[7]  = '{1, 8'h08, 8'h00, 8'h00, 3'd0, 0, 0};
        vt[8]  = '{0, 8'h08, 8'h08, 8'h08, 3'd3, 0, 0};
        vt[9]  = '{0, 8'h08, 8'h08, 8'h08, 3'd3, 1, 1};
        vt[10] = '{0, 8'h10, 8'h08, 8'h10, 3'd4, 1, 1};
        vt[11] = '{0, 8'h00, 8'h00, 8'h00, 3'd4, 0, 1};
        vt[12] = '{0, 8'h00, 8'h00, 8'h00, 3'd4, 0, 0};

        for (int v = 0; v < 13; v++) begin
            rst_r = vt[v].rst; req_r = vt[v].req; i_r = vt[v].i;
            tick();
            chk($sformatf("vec%0d gnt", v), 32'(if4.gnt), 32'(vt[v].gnt));
            chk($sformatf("vec%0d s", v), 32'(if4.s), 32'(vt[v].s));
            chk($sformatf("vec%0d y", v), 32'(if4.y), 32'(vt[v].y));
            chk($sformatf("vec%0d valid", v), 32'(if4.valid), 32'(vt[v].valid));
        end
        rst_r = 1'b0;

        // Sole requester keeps re-winning across HOLD_MAX boundaries.
        do_reset();
        req_r = 8'h04;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("sole c%0d gnt", c), 32'(if4.gnt), 32'h04);
            chk($sformatf("sole c%0d s", c), 32'(if4.s), 32'd2);
        end

        // Full rotation with wrap, four cycles per requester.
        do_reset();
        req_r = 8'hFF;
        for (int c = 1; c <= 36; c++) begin
            tick();
            chk($sformatf("rot c%0d gnt", c), 32'(if4.gnt), 32'(8'(1) << (((c - 1) / 4) % 8)));
            chk($sformatf("rot c%0d valid", c), 32'(if4.valid), (c >= 2) ? 32'd1 : 32'd0);
        end

        // Fairness after wrap on the HOLD_MAX=2 instance.
        do_reset();
        req_r = 8'h81;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("fair c%0d gnt", c), 32'(if2.gnt), (((c - 1) / 2) % 2 == 0) ? 32'h01 : 32'h80);
        end

        // Data integrity on the HOLD_MAX=1 instance.
        do_reset();
        req_r = 8'hFF; i_r = 8'hA5;
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk($sformatf("data c%0d s", c), 32'(if1.s), 32'((c - 1) % 8));
            if (c >= 2)
                chk($sformatf("data c%0d y", c), 32'(if1.y), 32'(y_seq[(c - 2) % 8]));
        end

        // Randomized traffic against the model on all three instances.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_r = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0: req_r = 8'h00;
                1: req_r = 8'(1) << $urandom_range(0, 7);
                default: req_r = 8'($urandom);
            endcase
            i_r = 8'($urandom);
            tick();
            chk_model($sformatf("rnd c%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
